// File: rtl/bitslip_align_pkg.sv
// Shared types and constants for the bitslip word-alignment controller.
package bitslip_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } align_state_t;

  localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'hF0;

  localparam int SETTLE_W = 4;
  localparam int MATCH_W  = 8;
  localparam int SLIP_W   = 4;
  localparam int LOSS_W   = 8;

endpackage

// File: rtl/bitslip_align_loss_monitor.sv
// Lock-loss watchdog: counts consecutive non-training words while locked and
// flags the mismatch that completes a run of LOSS_COUNT of them.
module align_loss_monitor
  import bitslip_align_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int         LOSS_COUNT    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_active,
  input  logic [7:0] i_data,
  output logic       o_loss_hit
);

  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_COUNT - 1);

  logic [LOSS_W-1:0] r_loss;
  logic              w_mismatch;

  assign w_mismatch = (i_data != TRAIN_PATTERN);
  assign o_loss_hit = i_active && w_mismatch && (r_loss == LOSS_LAST);

  // Leaving LOCKED always restarts the count from zero.
  always_ff @(posedge CLK) begin
    if (RST || !i_active || !w_mismatch || o_loss_hit) begin
      r_loss <= '0;
    end else begin
      r_loss <= r_loss + LOSS_W'(1);
    end
  end

endmodule

// File: rtl/bitslip_align.sv
// Word-alignment controller for an 8-bit deserializer: slips until the training
// pattern is seen MATCH_COUNT times in a row. Optional lock-loss re-alignment
// is enabled with `define BITSLIP_ALIGN_MONITOR_EN.
module bitslip_align
  import bitslip_align_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         MATCH_COUNT   = 16,
  parameter int         MAX_SLIPS     = 8,
  parameter int         LOSS_COUNT    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data_i,
  output logic       bitslip,
  output logic       locked,
  output logic       fail,
  output logic [3:0] slip_count,
  output logic [7:0] data_o,
  output logic       data_valid
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [SLIP_W-1:0]   SLIP_MAX    = SLIP_W'(MAX_SLIPS);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES out of range 1..15");
  end
  if (MATCH_COUNT < 1 || MATCH_COUNT > 255) begin : g_bad_match
    $error("MATCH_COUNT out of range 1..255");
  end
  if (MAX_SLIPS < 1 || MAX_SLIPS > 15) begin : g_bad_slips
    $error("MAX_SLIPS out of range 1..15");
  end
  if (LOSS_COUNT < 1 || LOSS_COUNT > 255) begin : g_bad_loss
    $error("LOSS_COUNT out of range 1..255");
  end

  align_state_t        r_state, w_state_nxt;
  logic [SETTLE_W-1:0] r_settle, w_settle_nxt;
  logic [MATCH_W-1:0]  r_match, w_match_nxt;
  logic [SLIP_W-1:0]   r_slip_cnt, w_slip_nxt;
  logic [7:0]          r_data_o;
  logic                r_data_valid;
  logic                w_word_match;
  logic                w_loss_hit;
  logic                w_restart;

  assign w_word_match = (data_i == TRAIN_PATTERN);

`ifdef BITSLIP_ALIGN_MONITOR_EN
  align_loss_monitor #(
    .TRAIN_PATTERN (TRAIN_PATTERN),
    .LOSS_COUNT    (LOSS_COUNT)
  ) u_loss_monitor (
    .CLK        (CLK),
    .RST        (RST),
    .i_active   (r_state == ST_LOCKED),
    .i_data     (data_i),
    .o_loss_hit (w_loss_hit)
  );
`else
  assign w_loss_hit = 1'b0;
`endif

  // NOTE: every next-value is given a default before the case so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_match_nxt  = r_match;
    w_slip_nxt   = r_slip_cnt;
    w_restart    = 1'b0;

    case (r_state)
      ST_IDLE, ST_FAIL: w_restart = start;
      ST_LOCKED:        w_restart = start | w_loss_hit;
      ST_WAIT: begin
        if (r_settle <= SETTLE_W'(1)) begin
          w_state_nxt = ST_CHECK;
          w_match_nxt = '0;
        end else begin
          w_settle_nxt = r_settle - SETTLE_W'(1);
        end
      end
      ST_CHECK: begin
        if (w_word_match) begin
          if (r_match == MATCH_LAST) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_match_nxt = r_match + MATCH_W'(1);
          end
        end else if (r_slip_cnt == SLIP_MAX) begin
          w_state_nxt = ST_FAIL;
        end else begin
          // Count lands with the SLIP state so both show in the pulse cycle.
          w_state_nxt = ST_SLIP;
          w_slip_nxt  = r_slip_cnt + SLIP_W'(1);
        end
      end
      ST_SLIP: begin
        w_state_nxt  = ST_WAIT;
        w_settle_nxt = SETTLE_LOAD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_restart) begin
      w_state_nxt  = ST_WAIT;
      w_settle_nxt = SETTLE_LOAD;
      w_slip_nxt   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_settle     <= '0;
      r_match      <= '0;
      r_slip_cnt   <= '0;
      r_data_o     <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle     <= w_settle_nxt;
      r_match      <= w_match_nxt;
      r_slip_cnt   <= w_slip_nxt;
      r_data_o     <= data_i;
      r_data_valid <= (r_state == ST_LOCKED);
    end
  end

  assign bitslip    = (r_state == ST_SLIP);
  assign locked     = (r_state == ST_LOCKED);
  assign fail       = (r_state == ST_FAIL);
  assign slip_count = r_slip_cnt;
  assign data_o     = r_data_o;
  assign data_valid = r_data_valid;

endmodule
